apb_cmd_master: RTL and testbench

//   Command-driven APB3 master that issues a single read or write transfer to a fixed

---
 rtl/apb_cmd_master_if.sv | 23 ++
 rtl/apb_cmd_master.sv | 92 +++++++++
 tb/tb_apb_cmd_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// APB3 bus bundle between the command master and an APB slave.
// Handshake: a transfer is offered when psel_o=1; penable_o=1 marks the access
// phase, and the transfer completes on the rising edge where psel_o, penable_o
// and pready_i are all 1 (prdata_i is valid only on that edge).
interface apb_cmd_master_if;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic        pready_i;
  logic [31:0] prdata_i;

  modport master (
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    input  pready_i, prdata_i
  );

  modport slave (
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    output pready_i, prdata_i
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Command-driven APB3 master: one read or write to a fixed address per command.
// Reads capture prdata; writes send the last captured value plus INCR.
// dbg_state_o encoding: 0 = IDLE, 1 = SETUP, 2 = ACCESS.
module apb_cmd_master #(
  parameter logic [31:0] TGT_ADDR = 32'hDEAD_CAFE,
  parameter logic [31:0] INCR     = 32'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                cmd_i,
  apb_cmd_master_if.master          bus,
  output logic [1:0]                dbg_state_o,
  output logic [31:0]               dbg_rdata_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  cmd_q;
  logic [31:0] rdata_q;
  logic        start;
  logic        done;

  // Only read and write start a transfer; 00 and 11 leave the bus idle.
  assign start = (state_q == IDLE) && ((cmd_i == CMD_RD) || (cmd_i == CMD_WR));
  assign done  = (state_q == ACCESS) && bus.pready_i;

  // State, latched command and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= 2'b00;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cmd_q <= cmd_i;
      end
      if (done && (cmd_q == CMD_RD)) begin
        rdata_q <= bus.prdata_i;
      end
    end
  end

  // Next state and bus outputs decoded from the registered state and command.
  always_comb begin
    state_d       = state_q;
    bus.psel_o    = 1'b0;
    bus.penable_o = 1'b0;
    bus.paddr_o   = 32'd0;
    bus.pwrite_o  = 1'b0;
    bus.pwdata_o  = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        bus.psel_o = 1'b1;
      end
      ACCESS: begin
        if (bus.pready_i) begin
          state_d = IDLE;
        end
        bus.psel_o    = 1'b1;
        bus.penable_o = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Address, direction and data are held constant for the whole transfer.
    if (bus.psel_o) begin
      bus.paddr_o  = TGT_ADDR;
      bus.pwrite_o = (cmd_q == CMD_WR);
      bus.pwdata_o = (cmd_q == CMD_WR) ? (rdata_q + INCR) : 32'd0;
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_rdata_o = rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a behavioural slave with random wait states and a
// transfer-level reference model tracking the last captured read value.
module tb_apb_cmd_master;

  localparam logic [31:0] TGT  = 32'hDEAD_CAFE;
  localparam logic [31:0] INCR = 32'd1;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [1:0]  cmd_i;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_rdata;

  apb_cmd_master_if bus ();

  apb_cmd_master #(.TGT_ADDR(TGT), .INCR(INCR)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_i       (cmd_i),
    .bus         (bus.master),
    .dbg_state_o (dbg_state),
    .dbg_rdata_o (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_read;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string ph, input logic [1:0] st, input logic psel,
                           input logic pen, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd);
    check({ph, ".state"},   {30'd0, dbg_state},     {30'd0, st});
    check({ph, ".psel"},    {31'd0, bus.psel_o},    {31'd0, psel});
    check({ph, ".penable"}, {31'd0, bus.penable_o}, {31'd0, pen});
    check({ph, ".paddr"},   bus.paddr_o,            addr);
    check({ph, ".pwrite"},  {31'd0, bus.pwrite_o},  {31'd0, wr});
    check({ph, ".pwdata"},  bus.pwdata_o,           wd);
  endtask

  task automatic check_idle(input string ph);
    check_bus(ph, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at a falling edge while the DUT is in IDLE; the
  // returning IDLE cycle is the mandatory gap before the next transfer.
  task automatic do_xfer(input logic [1:0] cmd, input int waits,
                         input logic [31:0] rd_val, input logic [1:0] mid_cmd);
    logic wr;
    wr = (cmd == 2'b10);
    exp_q.push_back(wr ? last_read + INCR : 32'd0);
    cmd_i = cmd;
    bus.pready_i = 1'b0;
    @(negedge clk);
    check_bus("setup", 2'd1, 1'b1, 1'b0, TGT, wr, exp_q[0]);
    cmd_i = mid_cmd;
    bus.pready_i = 1'($urandom_range(0, 1));
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check_bus("access", 2'd2, 1'b1, 1'b1, TGT, wr, exp_q[0]);
      bus.pready_i = (i == waits);
      bus.prdata_i = (i == waits) ? rd_val : $urandom();
    end
    @(negedge clk);
    bus.pready_i = 1'b0;
    bus.prdata_i = $urandom();
    cmd_i = 2'b00;
    if (!wr) last_read = rd_val;
    void'(exp_q.pop_front());
    check_idle("gap");
    check("rdata_q", dbg_rdata, last_read);
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] c);
    for (int i = 0; i < n; i++) begin
      cmd_i = c;
      @(negedge clk);
      check_idle("idle");
    end
    cmd_i = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    cmd_i        = 2'b01;
    bus.pready_i = 1'b0;
    bus.prdata_i = 32'd0;
    last_read    = 32'd0;

    // Reset held two cycles with a read request pending.
    @(posedge clk);
    @(negedge clk);
    check_idle("reset1");
    @(negedge clk);
    check_idle("reset2");
    check("reset.rdata", dbg_rdata, 32'd0);
    reset = 1'b0;
    cmd_i = 2'b00;
    idle_cycles(2, 2'b00);

    // Read with three wait states, then write of read+1.
    do_xfer(2'b01, 3, 32'h5, 2'b00);
    do_xfer(2'b10, 0, 32'hABCD_0000, 2'b00);
    check("after_write.rdata", dbg_rdata, 32'h5);

    // Alternating random transfers with random mid-transfer command noise.
    for (int k = 0; k < 10; k++) begin
      do_xfer((k % 2) ? 2'b10 : 2'b01, $urandom_range(1, 10),
              32'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end

    // Reserved command does nothing; a flip to write mid-read is ignored.
    idle_cycles(5, 2'b11);
    do_xfer(2'b01, 2, 32'h77, 2'b10);
    do_xfer(2'b10, 1, 32'h0, 2'b01);

    // Modulo wrap of the increment.
    do_xfer(2'b01, 1, 32'hFFFF_FFFF, 2'b00);
    do_xfer(2'b10, 2, 32'h1234_5678, 2'b00);

    // Reset asserted during ACCESS aborts and clears the captured data.
    cmd_i = 2'b01;
    @(negedge clk);
    check_bus("pre_abort.setup", 2'd1, 1'b1, 1'b0, TGT, 1'b0, 32'd0);
    cmd_i = 2'b00;
    @(negedge clk);
    check_bus("pre_abort.access", 2'd2, 1'b1, 1'b1, TGT, 1'b0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("abort");
    check("abort.rdata", dbg_rdata, 32'd0);
    reset = 1'b0;
    last_read = 32'd0;
    idle_cycles(1, 2'b00);
    do_xfer(2'b10, 0, 32'h0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
